// File: rtl/door_ctrl.sv
// rtl/door_ctrl.sv - elevator car-door sequencer driving the dwell timer handshake
// Optional reopen limit with nudge: define DOOR_REOPEN_LIMIT_EN.
module door_ctrl #(
  parameter int TRAVEL_CYC = 50_000_000,
  parameter int MAX_REOPEN = 3
) (
  input  logic clk_50M,
  input  logic rst_n,
  input  logic open_req,
  input  logic open_btn,
  input  logic close_btn,
  input  logic obstruct,
  input  logic delay_done,
  output logic delay_en,
  output logic motor_open,
  output logic motor_close,
  output logic door_closed,
  output logic door_open,
  output logic nudge
);

  localparam logic [2:0] S_CLOSED  = 3'd0;
  localparam logic [2:0] S_OPENING = 3'd1;
  localparam logic [2:0] S_OPEN    = 3'd2;
  localparam logic [2:0] S_REARM   = 3'd3;
  localparam logic [2:0] S_CLOSING = 3'd4;

  localparam logic [25:0] POS_MAX = 26'(TRAVEL_CYC);

  logic [2:0]  state, state_nxt;
  logic [25:0] pos, pos_nxt;
  logic        obstruct_reopens;

`ifdef DOOR_REOPEN_LIMIT_EN
  localparam int RW = ($clog2(MAX_REOPEN + 1) < 2) ? 2 : $clog2(MAX_REOPEN + 1);
  localparam logic [RW-1:0] RMAX = RW'(MAX_REOPEN);

  logic [RW-1:0] reopen_cnt, reopen_cnt_nxt;
  logic          at_limit;

  assign at_limit = (reopen_cnt == RMAX);
  // Once the limit is hit only a deliberate button press may reopen the door.
  assign obstruct_reopens = obstruct & ~at_limit;

  always_comb begin
    reopen_cnt_nxt = reopen_cnt;
    if (state_nxt == S_CLOSED)
      reopen_cnt_nxt = '0;
    else if (state == S_CLOSING && state_nxt == S_OPENING && !at_limit)
      reopen_cnt_nxt = reopen_cnt + 1'b1;
  end

  always_ff @(posedge clk_50M or negedge rst_n) begin
    if (!rst_n) begin
      reopen_cnt <= '0;
      nudge      <= 1'b0;
    end else begin
      reopen_cnt <= reopen_cnt_nxt;
      nudge      <= (reopen_cnt_nxt == RMAX);
    end
  end
`else
  assign obstruct_reopens = obstruct;
  assign nudge            = 1'b0;
`endif

  always_comb begin
    state_nxt = state;
    case (state)
      S_CLOSED:  if (open_req | open_btn) state_nxt = S_OPENING;
      S_OPENING: if (pos == POS_MAX) state_nxt = S_OPEN;
      S_OPEN: begin
        if (obstruct | open_btn)
          state_nxt = S_REARM;
        else if (close_btn | delay_done)
          state_nxt = S_CLOSING;
      end
      S_REARM:   state_nxt = S_OPEN;
      S_CLOSING: begin
        if (open_btn | obstruct_reopens)
          state_nxt = S_OPENING;
        else if (pos == '0)
          state_nxt = S_CLOSED;
      end
      default:   state_nxt = S_CLOSED;
    endcase
  end

  // Position tracks the cycles the motor is actually driven, so it follows the next state.
  always_comb begin
    pos_nxt = pos;
    if (state_nxt == S_OPENING && pos != POS_MAX)
      pos_nxt = pos + 26'd1;
    else if (state_nxt == S_CLOSING && pos != '0)
      pos_nxt = pos - 26'd1;
  end

  always_ff @(posedge clk_50M or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_CLOSED;
      pos         <= '0;
      motor_open  <= 1'b0;
      motor_close <= 1'b0;
      door_closed <= 1'b1;
      door_open   <= 1'b0;
      delay_en    <= 1'b0;
    end else begin
      state       <= state_nxt;
      pos         <= pos_nxt;
      motor_open  <= (state_nxt == S_OPENING);
      motor_close <= (state_nxt == S_CLOSING);
      door_closed <= (state_nxt == S_CLOSED);
      door_open   <= (state_nxt == S_OPEN) || (state_nxt == S_REARM);
      delay_en    <= (state_nxt == S_OPEN);
    end
  end

endmodule

// File: tb/tb_door_ctrl.sv
// tb/tb_door_ctrl.sv - self-checking bench for door_ctrl with a 20-cycle dwell timer
module tb_door_ctrl;

  localparam int TRAVEL = 4;
  localparam int DWELL  = 20;
  localparam int MAXR   = 3;
`ifdef DOOR_REOPEN_LIMIT_EN
  localparam bit LIMIT = 1'b1;
`else
  localparam bit LIMIT = 1'b0;
`endif

  // {motor_open, motor_close, door_open, door_closed, delay_en, nudge}
  localparam logic [5:0] V_CLOSED  = 6'b000100;
  localparam logic [5:0] V_OPENING = 6'b100000;
  localparam logic [5:0] V_OPEN    = 6'b001010;
  localparam logic [5:0] V_REARM   = 6'b001000;
  localparam logic [5:0] V_CLOSING = 6'b010000;

  // {open_req, open_btn, close_btn, obstruct}
  localparam logic [3:0] I_NONE = 4'b0000;
  localparam logic [3:0] I_REQ  = 4'b1000;
  localparam logic [3:0] I_BTN  = 4'b0100;
  localparam logic [3:0] I_CLS  = 4'b0010;
  localparam logic [3:0] I_OBS  = 4'b0001;

  logic clk_50M = 1'b0;
  logic rst_n;
  logic open_req, open_btn, close_btn, obstruct;
  logic delay_done;
  logic delay_en, motor_open, motor_close, door_closed, door_open, nudge;

  int vectors = 0;
  int miscompares = 0;

  always #10 clk_50M = ~clk_50M;

  door_ctrl #(.TRAVEL_CYC(TRAVEL), .MAX_REOPEN(MAXR)) dut (
    .clk_50M    (clk_50M),
    .rst_n      (rst_n),
    .open_req   (open_req),
    .open_btn   (open_btn),
    .close_btn  (close_btn),
    .obstruct   (obstruct),
    .delay_done (delay_done),
    .delay_en   (delay_en),
    .motor_open (motor_open),
    .motor_close(motor_close),
    .door_closed(door_closed),
    .door_open  (door_open),
    .nudge      (nudge)
  );

  // Dwell timer: done raised so that it is seen in the DWELL-th enabled cycle.
  int tmr_cnt;
  always @(posedge clk_50M or negedge rst_n) begin
    if (!rst_n) begin
      tmr_cnt    <= 0;
      delay_done <= 1'b0;
    end else if (!delay_en) begin
      tmr_cnt    <= 0;
      delay_done <= 1'b0;
    end else begin
      tmr_cnt    <= tmr_cnt + 1;
      delay_done <= (tmr_cnt + 1 >= DWELL - 1);
    end
  end

  // Reference model: door mode, position in travel cycles, cycles spent dwelling.
  typedef enum {M_CLOSED, M_OPENING, M_OPEN, M_REARM, M_CLOSING} mode_t;
  mode_t m_mode;
  int    m_pos, m_dwell, m_reopens;

  always @(posedge clk_50M or negedge rst_n) begin
    if (!rst_n) begin
      m_mode    <= M_CLOSED;
      m_pos     <= 0;
      m_dwell   <= 0;
      m_reopens <= 0;
    end else begin
      case (m_mode)
        M_CLOSED: if (open_req || open_btn) begin
          m_mode <= M_OPENING;
          m_pos  <= m_pos + 1;
        end
        M_OPENING: if (m_pos == TRAVEL) begin
          m_mode  <= M_OPEN;
          m_dwell <= 1;
        end else m_pos <= m_pos + 1;
        M_OPEN: if (obstruct || open_btn) m_mode <= M_REARM;
        else if (close_btn || m_dwell >= DWELL) begin
          m_mode <= M_CLOSING;
          m_pos  <= m_pos - 1;
        end else m_dwell <= m_dwell + 1;
        M_REARM: begin
          m_mode  <= M_OPEN;
          m_dwell <= 1;
        end
        M_CLOSING: if (open_btn || (obstruct && !(LIMIT && m_reopens == MAXR))) begin
          m_mode <= M_OPENING;
          m_pos  <= (m_pos < TRAVEL) ? m_pos + 1 : m_pos;
          if (m_reopens < MAXR) m_reopens <= m_reopens + 1;
        end else if (m_pos == 0) begin
          m_mode    <= M_CLOSED;
          m_reopens <= 0;
        end else m_pos <= m_pos - 1;
        default: m_mode <= M_CLOSED;
      endcase
    end
  end

  function automatic logic [5:0] model_vec();
    return {m_mode == M_OPENING, m_mode == M_CLOSING,
            m_mode == M_OPEN || m_mode == M_REARM, m_mode == M_CLOSED,
            m_mode == M_OPEN,
            LIMIT && m_reopens == MAXR && m_mode != M_CLOSED};
  endfunction

  task automatic check(input string name, input logic [5:0] exp);
    logic [5:0] act;
    act = {motor_open, motor_close, door_open, door_closed, delay_en, nudge};
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %b expected %b (mo,mc,do,dc,en,nudge)", name, act, exp);
    end
  endtask

  task automatic drive(input logic [3:0] in);
    {open_req, open_btn, close_btn, obstruct} = in;
    @(posedge clk_50M);
    @(negedge clk_50M);
  endtask

  typedef struct {
    logic [3:0] in;
    int         n;
    logic [5:0] exp;
  } vec_t;

  vec_t tbl[$];

  initial begin
    // Directed sequences: normal cycle, obstruct during dwell and closing, close+obstruct.
    tbl.push_back('{I_NONE, 1, V_CLOSED});
    tbl.push_back('{I_OBS, 1, V_CLOSED});
    tbl.push_back('{I_CLS, 1, V_CLOSED});
    tbl.push_back('{I_REQ, 1, V_OPENING});
    tbl.push_back('{I_NONE, 3, V_OPENING});
    tbl.push_back('{I_NONE, 20, V_OPEN});
    tbl.push_back('{I_NONE, 4, V_CLOSING});
    tbl.push_back('{I_NONE, 1, V_CLOSED});
    tbl.push_back('{I_REQ, 1, V_OPENING});
    tbl.push_back('{I_NONE, 3, V_OPENING});
    tbl.push_back('{I_NONE, 10, V_OPEN});
    tbl.push_back('{I_OBS, 1, V_REARM});
    tbl.push_back('{I_NONE, 20, V_OPEN});
    tbl.push_back('{I_NONE, 2, V_CLOSING});
    tbl.push_back('{I_OBS, 1, V_OPENING});
    tbl.push_back('{I_NONE, 1, V_OPENING});
    tbl.push_back('{I_NONE, 1, V_OPEN});
    tbl.push_back('{I_REQ, 1, V_OPEN});
    tbl.push_back('{I_NONE, 18, V_OPEN});
    tbl.push_back('{I_NONE, 4, V_CLOSING});
    tbl.push_back('{I_NONE, 1, V_CLOSED});
    tbl.push_back('{I_BTN, 1, V_OPENING});
    tbl.push_back('{I_NONE, 3, V_OPENING});
    tbl.push_back('{I_NONE, 1, V_OPEN});
    tbl.push_back('{I_CLS | I_OBS, 1, V_REARM});
    tbl.push_back('{I_NONE, 1, V_OPEN});
    tbl.push_back('{I_CLS, 1, V_CLOSING});
    tbl.push_back('{I_NONE, 3, V_CLOSING});
    tbl.push_back('{I_NONE, 1, V_CLOSED});

    {open_req, open_btn, close_btn, obstruct} = I_NONE;
    rst_n = 1'b1;
    #3 rst_n = 1'b0;
    #1 check("reset", V_CLOSED);
    @(negedge clk_50M);
    rst_n = 1'b1;

    foreach (tbl[i])
      for (int k = 0; k < tbl[i].n; k++) begin
        drive(tbl[i].in);
        check($sformatf("tbl%0d.%0d", i, k), tbl[i].exp);
      end

    // Reset in the middle of opening travel.
    drive(I_REQ);
    drive(I_NONE);
    check("mid_opening", V_OPENING);
    rst_n = 1'b0;
    #1 check("rst_async", V_CLOSED);
    @(negedge clk_50M);
    check("rst_hold", V_CLOSED);
    rst_n = 1'b1;
    drive(I_NONE);
    check("rst_release", V_CLOSED);
    drive(I_REQ);
    check("reopen_after_rst", V_OPENING);
    for (int k = 0; k < 3; k++) begin
      drive(I_NONE);
      check("full_travel_after_rst", V_OPENING);
    end
    drive(I_NONE);
    check("open_after_rst", V_OPEN);
    drive(I_CLS);
    check("close_after_rst", V_CLOSING);
    for (int k = 0; k < 4; k++) drive(I_NONE);
    check("closed_after_rst", V_CLOSED);

    // Repeated obstruct reopens during closing.
    drive(I_REQ);
    for (int k = 0; k < 4; k++) drive(I_NONE);
    check("reopen_seq_open", V_OPEN);
    drive(I_CLS);
    for (int r = 1; r <= 4; r++) begin
      drive(I_OBS);
      if (r < 3)
        check($sformatf("reopen%0d", r), V_OPENING);
      else if (r == 3)
        check("reopen3", LIMIT ? (V_OPENING | 6'b000001) : V_OPENING);
      else
        check("reopen4", LIMIT ? (V_CLOSING | 6'b000001) : V_OPENING);
      drive(I_NONE);
      check($sformatf("reopen%0d_model", r), model_vec());
      drive(I_CLS);
      check($sformatf("reopen%0d_close", r), model_vec());
    end
    for (int k = 0; k < 40; k++) drive(I_CLS);
    check("reopen_closed", V_CLOSED);

    // Randomized stimulus against the reference model.
    for (int seg = 0; seg < 8; seg++) begin
      int p_obs;
      p_obs = (seg % 4) * 4;
      for (int k = 0; k < 500; k++) begin
        logic [3:0] in;
        in[3] = ($urandom_range(0, 99) < 12);
        in[2] = ($urandom_range(0, 99) < 4);
        in[1] = ($urandom_range(0, 99) < 8);
        in[0] = ($urandom_range(0, 99) < p_obs);
        drive(in);
        check($sformatf("rand%0d.%0d", seg, k), model_vec());
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
